bitstream_decoder: RTL and testbench
====================================

BITSTREAM_DECODER -- requirements
Module: bitstream_decoder

Interface
REQ-001 Parameter LENGTH, default 255: number of valid bitstream samples per conversion window; legal range 1 to 2**WIDTH-1.
REQ-002 Parameter WIDTH, default 8: width of the sample counter, ones counter and value output.
REQ-003 clk  input  1  system clock; all state changes on the rising edge; one clock domain only.
REQ-004 n_rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin a conversion window; sampled on the rising edge.
REQ-006 abort  input  1  synchronous cancel of the window in progress.
REQ-007 continuous  input  1  when 1, a new window starts automatically after each completed window.
REQ-008 bit_in  input  1  stochastic bitstream sample from the network output.
REQ-009 bit_valid  input  1  qualifies bit_in; a sample counts only when bit_valid=1.
REQ-010 value  output  WIDTH  number of 1s in the last completed window; held until the next completion.
REQ-011 done  output  1  single-cycle pulse marking an update of value.
REQ-012 busy  output  1  1 while a window is open (FSM state COUNT).

Function
REQ-013 The FSM SHALL have two states, IDLE and COUNT, with state, samples counter and ones counter as registers.
REQ-014 IDLE: if start=1 and abort=0, go to COUNT with samples=0 and ones=0; otherwise stay in IDLE, and bit_in/bit_valid are ignored.
REQ-015 COUNT: on each cycle with bit_valid=1, samples increments by 1 and ones increments by bit_in.
REQ-016 Completion is the COUNT cycle in which bit_valid=1 and samples=LENGTH-1. On that edge, value SHALL load ones+bit_in, so the final sample is included.
REQ-017 done SHALL be 1 in exactly the cycle after the completion edge (registered), and 0 in all other cycles.
REQ-018 At completion with continuous=1, the FSM stays in COUNT and clears samples and ones on the same edge, so no sample is lost between windows.
REQ-019 At completion with continuous=0, the FSM returns to IDLE.
REQ-020 start asserted while in COUNT SHALL be ignored; it does not restart the window.
REQ-021 abort=1 in COUNT: go to IDLE and clear samples and ones; value is unchanged and done is not pulsed. abort has priority over completion in the same cycle.
REQ-022 abort=1 and start=1 together in IDLE: remain in IDLE.
REQ-023 Cycles with bit_valid=0 in COUNT SHALL leave both counters unchanged; there is no timeout.
REQ-024 Counters SHALL never wrap: the ones counter is bounded by samples, and samples is cleared at LENGTH.
REQ-025 Latency: done rises 1 cycle after the clock edge that accepts the LENGTH-th valid sample.
REQ-026 busy SHALL be a direct decode of state==COUNT.

Reset
REQ-027 While n_rst=0, independent of clk: state=IDLE, samples=0, ones=0, value=0, done=0, busy=0.
REQ-028 Reset asserted mid-window SHALL discard the window with no done pulse; after release the block waits in IDLE for start.
REQ-029 The first rising edge after n_rst deasserts SHALL behave as a normal IDLE cycle.

Verification
REQ-030 LENGTH=255: start, then 255 consecutive valid samples with a 1 on every 3rd sample -> done 1 cycle after the 255th sample, value=85, busy=0 afterwards.
REQ-031 LENGTH=4, bits 1,1,1,1 with bit_valid gaps inserted -> value=4 after the 4th valid bit only; done pulse width exactly 1 cycle.
REQ-032 continuous=1, LENGTH=4, alternating 1/0 for 12 valid cycles -> done in 3 cycles, each with value=2; busy stays 1 throughout.
REQ-033 abort on the same cycle as the completing sample -> no done pulse, value keeps its previous result, state=IDLE.
REQ-034 n_rst pulsed low mid-window, then a full window of all 1s (LENGTH=255) -> value=0 during reset, then value=255 with a single done pulse.
REQ-035 start re-pulsed mid-window -> window length unaffected; completion occurs at the original LENGTH count.

Source files
------------

// File: rtl/bitstream_decoder.sv
// Stochastic bitstream decoder: counts 1s over a window of LENGTH valid samples
// and publishes the count on value with a single-cycle done pulse.
module bitstream_decoder #(
    parameter int LENGTH = 255,
    parameter int WIDTH  = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             abort,
    input  logic             continuous,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [WIDTH-1:0] value,
    output logic             done,
    output logic             busy
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    // Sample index of the last sample in a window.
    localparam logic [WIDTH-1:0] LAST = WIDTH'(LENGTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_samples;
    logic [WIDTH-1:0] r_ones;
    logic [WIDTH-1:0] r_value;
    logic             r_done;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_samples_nxt;
    logic [WIDTH-1:0] w_ones_nxt;
    logic [WIDTH-1:0] w_value_nxt;
    logic             w_done_nxt;
    logic [WIDTH-1:0] w_bit_ext;

    assign w_bit_ext = WIDTH'(bit_in);

    // Next-state, counter and result logic for the IDLE/COUNT window FSM.
    always_comb begin
        w_state_nxt   = r_state;
        w_samples_nxt = r_samples;
        w_ones_nxt    = r_ones;
        w_value_nxt   = r_value;
        w_done_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    w_state_nxt   = COUNT;
                    w_samples_nxt = {WIDTH{1'b0}};
                    w_ones_nxt    = {WIDTH{1'b0}};
                end else begin
                    w_state_nxt   = IDLE;
                end
            end
            COUNT: begin
                // Abort wins over a completing sample in the same cycle.
                if (abort) begin
                    w_state_nxt   = IDLE;
                    w_samples_nxt = {WIDTH{1'b0}};
                    w_ones_nxt    = {WIDTH{1'b0}};
                end else if (bit_valid) begin
                    if (r_samples == LAST) begin
                        w_value_nxt   = r_ones + w_bit_ext;
                        w_done_nxt    = 1'b1;
                        w_samples_nxt = {WIDTH{1'b0}};
                        w_ones_nxt    = {WIDTH{1'b0}};
                        if (continuous) begin
                            w_state_nxt = COUNT;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_samples_nxt = r_samples + WIDTH'(1);
                        w_ones_nxt    = r_ones + w_bit_ext;
                    end
                end else begin
                    w_state_nxt = COUNT;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_samples_nxt = {WIDTH{1'b0}};
                w_ones_nxt    = {WIDTH{1'b0}};
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= IDLE;
            r_samples <= {WIDTH{1'b0}};
            r_ones    <= {WIDTH{1'b0}};
            r_value   <= {WIDTH{1'b0}};
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_samples <= w_samples_nxt;
            r_ones    <= w_ones_nxt;
            r_value   <= w_value_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign value = r_value;
    assign done  = r_done;
    assign busy  = (r_state == COUNT);

endmodule

// File: tb/tb_bitstream_decoder.sv
// Directed bench for bitstream_decoder: one instance with LENGTH=255, one with LENGTH=4.
module tb_bitstream_decoder;

    logic       clk;
    logic       n_rst;

    logic       start_a, abort_a, cont_a, bit_a, valid_a;
    logic [7:0] value_a;
    logic       done_a, busy_a;

    logic       start_b, abort_b, cont_b, bit_b, valid_b;
    logic [7:0] value_b;
    logic       done_b, busy_b;

    int total;
    int bad;
    int pulses;

    bitstream_decoder #(.LENGTH(255), .WIDTH(8)) u_dut_a (
        .clk(clk), .n_rst(n_rst), .start(start_a), .abort(abort_a),
        .continuous(cont_a), .bit_in(bit_a), .bit_valid(valid_a),
        .value(value_a), .done(done_a), .busy(busy_a)
    );

    bitstream_decoder #(.LENGTH(4), .WIDTH(8)) u_dut_b (
        .clk(clk), .n_rst(n_rst), .start(start_b), .abort(abort_b),
        .continuous(cont_b), .bit_in(bit_b), .bit_valid(valid_b),
        .value(value_b), .done(done_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0; pulses = 0;
        n_rst = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; cont_a = 1'b0; bit_a = 1'b0; valid_a = 1'b0;
        start_b = 1'b0; abort_b = 1'b0; cont_b = 1'b0; bit_b = 1'b0; valid_b = 1'b0;
        #2;
        chk("rst_value_a", value_a, 0);
        chk("rst_done_a", done_a, 0);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_value_b", value_b, 0);
        chk("rst_done_b", done_b, 0);
        chk("rst_busy_b", busy_b, 0);
        #10;
        n_rst = 1'b1;
        tick();
        chk("first_edge_idle", busy_a, 0);

        // 255 samples, a 1 on every third -> 85
        start_a = 1'b1;
        tick();
        chk("l255_busy_start", busy_a, 1);
        start_a = 1'b0;
        for (int i = 0; i < 255; i++) begin
            valid_a = 1'b1;
            bit_a   = ((i % 3) == 2) ? 1'b1 : 1'b0;
            if (i == 254) chk("l255_no_early_done", done_a, 0);
            tick();
        end
        valid_a = 1'b0; bit_a = 1'b0;
        chk("l255_done", done_a, 1);
        chk("l255_value", value_a, 85);
        chk("l255_busy_after", busy_a, 0);
        tick();
        chk("l255_done_low", done_a, 0);
        chk("l255_value_held", value_a, 85);

        // reset mid-window, then a full window of 1s
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 100; i++) begin
            valid_a = 1'b1; bit_a = 1'b1;
            tick();
        end
        n_rst = 1'b0;
        #1;
        chk("midrst_value", value_a, 0);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_done", done_a, 0);
        tick();
        n_rst = 1'b1;
        tick();
        chk("postrst_idle", busy_a, 0);
        chk("postrst_no_done", done_a, 0);
        start_a = 1'b1; valid_a = 1'b0;
        tick();
        start_a = 1'b0;
        pulses = 0;
        for (int i = 0; i < 255; i++) begin
            valid_a = 1'b1; bit_a = 1'b1;
            tick();
            if (done_a === 1'b1) pulses++;
        end
        valid_a = 1'b0; bit_a = 1'b0;
        chk("ones_done", done_a, 1);
        chk("ones_value", value_a, 255);
        tick();
        if (done_a === 1'b1) pulses++;
        chk("ones_single_pulse", pulses, 1);

        // start re-pulsed mid-window: first 10 samples are 1 -> 10
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        pulses = 0;
        for (int i = 0; i < 255; i++) begin
            valid_a = 1'b1;
            bit_a   = (i < 10) ? 1'b1 : 1'b0;
            start_a = (i == 120) ? 1'b1 : 1'b0;
            tick();
            if (i < 254 && done_a === 1'b1) pulses++;
        end
        valid_a = 1'b0; bit_a = 1'b0; start_a = 1'b0;
        chk("restart_no_early", pulses, 0);
        chk("restart_done", done_a, 1);
        chk("restart_value", value_a, 10);

        // LENGTH=4, all 1s with valid gaps
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        valid_b = 1'b1; bit_b = 1'b1; tick();
        valid_b = 1'b0; bit_b = 1'b1; tick();
        valid_b = 1'b1; bit_b = 1'b1; tick();
        valid_b = 1'b0; bit_b = 1'b0; tick();
        valid_b = 1'b0; bit_b = 1'b1; tick();
        valid_b = 1'b1; bit_b = 1'b1; tick();
        chk("gap_no_done_3", done_b, 0);
        chk("gap_value_3", value_b, 0);
        chk("gap_busy_3", busy_b, 1);
        valid_b = 1'b0; bit_b = 1'b1; tick();
        valid_b = 1'b1; bit_b = 1'b1; tick();
        valid_b = 1'b0; bit_b = 1'b0;
        chk("gap_done", done_b, 1);
        chk("gap_value", value_b, 4);
        chk("gap_busy_after", busy_b, 0);
        tick();
        chk("gap_pulse_width", done_b, 0);

        // continuous, alternating 1/0 for 12 valid cycles
        cont_b = 1'b1; start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 12; i++) begin
            valid_b = 1'b1;
            bit_b   = ((i % 2) == 0) ? 1'b1 : 1'b0;
            tick();
            chk("cont_busy", busy_b, 1);
            if ((i % 4) == 3) begin
                chk("cont_done", done_b, 1);
                chk("cont_value", value_b, 2);
            end else begin
                chk("cont_no_done", done_b, 0);
            end
        end
        valid_b = 1'b0; bit_b = 1'b0; cont_b = 1'b0;
        abort_b = 1'b1;
        tick();
        abort_b = 1'b0;
        chk("cont_abort_idle", busy_b, 0);
        chk("cont_abort_no_done", done_b, 0);

        // abort coinciding with the completing sample
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid_b = 1'b1; bit_b = 1'b1;
            tick();
        end
        abort_b = 1'b1; valid_b = 1'b1; bit_b = 1'b1;
        tick();
        abort_b = 1'b0; valid_b = 1'b0; bit_b = 1'b0;
        chk("abort_no_done", done_b, 0);
        chk("abort_value_kept", value_b, 2);
        chk("abort_idle", busy_b, 0);
        tick();
        chk("abort_no_done_late", done_b, 0);

        // start and abort together in IDLE
        start_b = 1'b1; abort_b = 1'b1;
        tick();
        start_b = 1'b0; abort_b = 1'b0;
        chk("start_abort_idle", busy_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
